// File: rtl/dnn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dnn_pkg
// Brief   : Shared widths and the queued result record for the DNN back end.
// Revision: 1.0  initial release
// ============================================================================
package dnn_pkg;

    localparam int DNN_OUT_W = 21;
    localparam int DNN_RES_W = 12;

    typedef struct packed {
        logic                        cls;
        logic                        sat;
        logic signed [DNN_RES_W-1:0] r0;
        logic signed [DNN_RES_W-1:0] r1;
    } dnn_result_t;

endpackage
`default_nettype wire

// File: rtl/dnn_sat.sv
`default_nettype none
// ============================================================================
// Module  : dnn_sat
// Brief   : Combinational signed saturator, IN_W -> OUT_W with clip flag.
// Revision: 1.0  initial release
// ============================================================================
module dnn_sat #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 12
) (
    input  logic [IN_W-1:0]  i_din,
    output logic [OUT_W-1:0] o_dout,
    output logic             o_sat
);

    // Output range limits, sign-extended to the input width for comparison
    localparam logic [IN_W-1:0] c_max_in = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [IN_W-1:0] c_min_in = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        o_dout = i_din[OUT_W-1:0];
        o_sat  = 1'b0;
        if ($signed(i_din) > $signed(c_max_in)) begin
            o_dout = {1'b0, {(OUT_W-1){1'b1}}};
            o_sat  = 1'b1;
        end else if ($signed(i_din) < $signed(c_min_in)) begin
            o_dout = {1'b1, {(OUT_W-1){1'b0}}};
            o_sat  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dnn_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : dnn_result_collector
// Brief   : Captures/saturates DNN outputs, labels the class and queues them
//           in a show-ahead FIFO drained over valid/ready; sticky error flags.
// Revision: 1.0  initial release
// ============================================================================
module dnn_result_collector
    import dnn_pkg::*;
#(
    parameter int OUT_W = DNN_OUT_W,
    parameter int RES_W = DNN_RES_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OUT_W-1:0]         out0,
    input  logic [OUT_W-1:0]         out1,
    input  logic                     out0_ready,
    input  logic                     out1_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res0,
    output logic [RES_W-1:0]         res1,
    output logic                     res_class,
    output logic                     res_sat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     proto_err,
    input  logic                     clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_proto_err;
    dnn_result_t      r_mem [DEPTH];

    logic [RES_W-1:0] w_sat0;
    logic [RES_W-1:0] w_sat1;
    logic             w_clip0;
    logic             w_clip1;
    logic             w_capture;
    logic             w_full;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    dnn_result_t      w_entry;
    dnn_result_t      w_head;

    dnn_sat #(.IN_W(OUT_W), .OUT_W(RES_W)) u_sat0 (
        .i_din  (out0),
        .o_dout (w_sat0),
        .o_sat  (w_clip0)
    );

    dnn_sat #(.IN_W(OUT_W), .OUT_W(RES_W)) u_sat1 (
        .i_din  (out1),
        .o_dout (w_sat1),
        .o_sat  (w_clip1)
    );

    assign w_capture = out0_ready & out1_ready;
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid & res_ready;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign w_push    = w_capture & (~w_full | w_pop);

    always_comb begin
        w_entry     = '0;
        w_entry.cls = ($signed(out1) > $signed(out0));
        w_entry.sat = w_clip0 | w_clip1;
        w_entry.r0  = w_sat0;
        w_entry.r1  = w_sat1;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            // Set events win over a coincident clear
            if (w_capture && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (out0_ready ^ out1_ready) begin
                r_proto_err <= 1'b1;
            end else if (clr_err) begin
                r_proto_err <= 1'b0;
            end
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign res_valid = w_valid;
    assign res0      = w_valid ? w_head.r0  : '0;
    assign res1      = w_valid ? w_head.r1  : '0;
    assign res_class = w_valid ? w_head.cls : 1'b0;
    assign res_sat   = w_valid ? w_head.sat : 1'b0;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_dnn_result_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_dnn_result_collector
// Brief   : Directed self-checking bench for dnn_result_collector.
// Revision: 1.0  initial release
// ============================================================================
module tb_dnn_result_collector;

    localparam int OUT_W = 21;
    localparam int RES_W = 12;
    localparam int DEPTH = 4;

    logic                     clk;
    logic                     rst;
    logic signed [OUT_W-1:0]  out0;
    logic signed [OUT_W-1:0]  out1;
    logic                     out0_ready;
    logic                     out1_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [RES_W-1:0]  res0;
    logic signed [RES_W-1:0]  res1;
    logic                     res_class;
    logic                     res_sat;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     proto_err;
    logic                     clr_err;

    int errors = 0;
    int checks = 0;

    dnn_result_collector #(.OUT_W(OUT_W), .RES_W(RES_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .out0       (out0),
        .out1       (out1),
        .out0_ready (out0_ready),
        .out1_ready (out1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res0       (res0),
        .res1       (res1),
        .res_class  (res_class),
        .res_sat    (res_sat),
        .count      (count),
        .overflow   (overflow),
        .proto_err  (proto_err),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic capture(input int a, input int b);
        @(negedge clk);
        out0 = OUT_W'(a); out1 = OUT_W'(b);
        out0_ready = 1'b1; out1_ready = 1'b1;
        @(negedge clk);
        out0_ready = 1'b0; out1_ready = 1'b0;
    endtask

    task automatic pop_one();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", res_valid); end
        checks++; if (count !== 0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (overflow !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%0b perr=%0b want 0 0", overflow, proto_err); end
        checks++; if (res0 !== 0 || res1 !== 0) begin errors++; $display("FAIL reset_res: got %0d %0d want 0 0", res0, res1); end
    endtask

    task automatic test_basic();
        capture(100, -50);
        checks++; if (res_valid !== 1'b1 || count !== 1) begin errors++; $display("FAIL basic_valid: got v=%0b cnt=%0d want 1 1", res_valid, count); end
        checks++; if (res0 !== 100 || res1 !== -50) begin errors++; $display("FAIL basic_res: got %0d %0d want 100 -50", res0, res1); end
        checks++; if (res_class !== 1'b0 || res_sat !== 1'b0) begin errors++; $display("FAIL basic_cls: got c=%0b s=%0b want 0 0", res_class, res_sat); end
        pop_one();
        checks++; if (res_valid !== 1'b0 || count !== 0 || res0 !== 0) begin errors++; $display("FAIL basic_pop: got v=%0b cnt=%0d r0=%0d want 0 0 0", res_valid, count, res0); end
    endtask

    task automatic test_saturate();
        capture(5000, -3000);
        checks++; if (res0 !== 2047 || res1 !== -2048 || res_sat !== 1'b1 || res_class !== 1'b0) begin errors++;
            $display("FAIL sat_clip: got %0d %0d s=%0b c=%0b want 2047 -2048 1 0", res0, res1, res_sat, res_class); end
        pop_one();
        capture(-10, -10);
        checks++; if (res0 !== -10 || res_class !== 1'b0 || res_sat !== 1'b0) begin errors++;
            $display("FAIL sat_tie: got %0d c=%0b s=%0b want -10 0 0", res0, res_class, res_sat); end
        pop_one();
        capture(-4, 7);
        checks++; if (res_class !== 1'b1 || res0 !== -4 || res1 !== 7) begin errors++;
            $display("FAIL sat_class1: got c=%0b %0d %0d want 1 -4 7", res_class, res0, res1); end
        pop_one();
        capture(2047, -2048);
        checks++; if (res0 !== 2047 || res1 !== -2048 || res_sat !== 1'b0) begin errors++;
            $display("FAIL sat_edge: got %0d %0d s=%0b want 2047 -2048 0", res0, res1, res_sat); end
        pop_one();
        capture(2048, -2049);
        checks++; if (res0 !== 2047 || res1 !== -2048 || res_sat !== 1'b1) begin errors++;
            $display("FAIL sat_edge1: got %0d %0d s=%0b want 2047 -2048 1", res0, res1, res_sat); end
        pop_one();
    endtask

    task automatic test_overflow();
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            out0 = OUT_W'(i); out1 = '0; out0_ready = 1'b1; out1_ready = 1'b1;
            @(negedge clk);
        end
        out0_ready = 1'b0; out1_ready = 1'b0;
        checks++; if (count !== 4 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_fill: got cnt=%0d ovf=%0b want 4 1", count, overflow); end
        res_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (res_valid !== 1'b1 || res0 !== k) begin errors++; $display("FAIL ovf_drain%0d: got v=%0b r0=%0d want 1 %0d", k, res_valid, res0, k); end
            @(negedge clk);
        end
        res_ready = 1'b0;
        checks++; if (count !== 0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got cnt=%0d ovf=%0b want 0 1", count, overflow); end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        @(negedge clk);
        for (int i = 10; i <= 13; i++) begin
            out0 = OUT_W'(i); out1 = '0; out0_ready = 1'b1; out1_ready = 1'b1;
            @(negedge clk);
        end
        checks++; if (count !== 4) begin errors++; $display("FAIL fpp_fill: got cnt=%0d want 4", count); end
        out0 = 21'sd14; res_ready = 1'b1;
        @(negedge clk);
        out0_ready = 1'b0; out1_ready = 1'b0; res_ready = 1'b0;
        checks++; if (count !== 4 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_count: got cnt=%0d ovf=%0b want 4 0", count, overflow); end
        res_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            checks++; if (res0 !== k) begin errors++; $display("FAIL fpp_drain%0d: got r0=%0d want %0d", k, res0, k); end
            @(negedge clk);
        end
        res_ready = 1'b0;
        checks++; if (count !== 0 || res_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got cnt=%0d v=%0b want 0 0", count, res_valid); end
    endtask

    task automatic test_proto();
        @(negedge clk);
        out0_ready = 1'b1; out1_ready = 1'b0;
        @(negedge clk);
        out0_ready = 1'b0;
        checks++; if (proto_err !== 1'b1 || count !== 0) begin errors++; $display("FAIL proto_set: got perr=%0b cnt=%0d want 1 0", proto_err, count); end
        // Clear coincident with a new mismatch: the set must win
        out1_ready = 1'b1; clr_err = 1'b1;
        @(negedge clk);
        out1_ready = 1'b0;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_prio: got %0b want 1", proto_err); end
        @(negedge clk);
        clr_err = 1'b0;
        checks++; if (proto_err !== 1'b0 || count !== 0) begin errors++; $display("FAIL proto_clr: got perr=%0b cnt=%0d want 0 0", proto_err, count); end
    endtask

    task automatic test_reset_midop();
        capture(1, 1); capture(2, 2); capture(3, 3);
        checks++; if (count !== 3) begin errors++; $display("FAIL rmid_fill: got cnt=%0d want 3", count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (count !== 0 || res_valid !== 1'b0 || res0 !== 0) begin errors++;
            $display("FAIL rmid_async: got cnt=%0d v=%0b r0=%0d want 0 0 0", count, res_valid, res0); end
        @(negedge clk);
        rst = 1'b0;
        capture(100, -50);
        checks++; if (res_valid !== 1'b1 || count !== 1 || res0 !== 100 || res1 !== -50) begin errors++;
            $display("FAIL rmid_after: got v=%0b cnt=%0d %0d %0d want 1 1 100 -50", res_valid, count, res0, res1); end
        pop_one();
    endtask

    initial begin
        rst = 1'b1;
        out0 = '0; out1 = '0; out0_ready = 1'b0; out1_ready = 1'b0;
        res_ready = 1'b0; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_saturate();
        test_overflow();
        test_full_push_pop();
        test_proto();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
